jpeg_mcu_scheduler: RTL and testbench

JPEG_MCU_SCHEDULER -- requirements
Module: jpeg_mcu_scheduler

---
 rtl/jpeg_pkg.sv | 59 +++++
 rtl/jpeg_mcu_counter.sv | 72 +++++++
 rtl/jpeg_mcu_scheduler.sv | 164 ++++++++++++++++
 tb/tb_jpeg_mcu_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared encodings for the JPEG MCU scheduler: sampling modes, component codes,
// FSM states and small decode helpers used by the scheduler datapath.
package jpeg_pkg;

    typedef enum logic [1:0] {
        SAMP_GRAY = 2'd0,
        SAMP_444  = 2'd1,
        SAMP_420  = 2'd2,
        SAMP_RSVD = 2'd3
    } samp_mode_e;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BLK_W = 3;

    // The reserved mode decodes exactly like grayscale.
    function automatic samp_mode_e norm_mode(input logic [1:0] m);
        samp_mode_e r;
        r = samp_mode_e'(m);
        if (r == SAMP_RSVD) begin
            r = SAMP_GRAY;
        end
        return r;
    endfunction

    // Index of the last block inside one MCU for a sampling mode.
    function automatic logic [BLK_W-1:0] last_blk(input samp_mode_e m);
        logic [BLK_W-1:0] r;
        case (m)
            SAMP_444: r = 3'd2;
            SAMP_420: r = 3'd5;
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

    // Component carried by a given block slot of the MCU.
    function automatic comp_e blk_comp(input samp_mode_e m, input logic [BLK_W-1:0] blk);
        comp_e c;
        case (m)
            SAMP_444: c = (blk == 3'd1) ? COMP_CB : ((blk == 3'd2) ? COMP_CR : COMP_Y);
            SAMP_420: c = (blk == 3'd4) ? COMP_CB : ((blk == 3'd5) ? COMP_CR : COMP_Y);
            default:  c = COMP_Y;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/jpeg_mcu_counter.sv
// Nested block / MCU-column / MCU-row counter walking an image in raster order.
// Flags the final block of the final MCU so the scheduler knows when to stop.
module jpeg_mcu_counter
    import jpeg_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [2:0]       blk_last,
    input  logic [DIM_W-1:0] x_last,
    input  logic [DIM_W-1:0] y_last,
    output logic [2:0]       blk,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic             last
);

    logic [2:0]       blk_q, blk_d;
    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic             blk_wrap, x_wrap, y_wrap;

    assign blk_wrap = (blk_q == blk_last);
    assign x_wrap   = (x_q == x_last);
    assign y_wrap   = (y_q == y_last);

    assign blk  = blk_q;
    assign x    = x_q;
    assign y    = y_q;
    assign last = blk_wrap && x_wrap && y_wrap;

    // Next position: block first, then column, then row; everything wraps to zero.
    always_comb begin
        blk_d = blk_q;
        x_d   = x_q;
        y_d   = y_q;
        if (clr) begin
            blk_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (adv) begin
            if (!blk_wrap) begin
                blk_d = blk_q + 3'd1;
            end else begin
                blk_d = '0;
                if (!x_wrap) begin
                    x_d = x_q + DIM_W'(1);
                end else begin
                    x_d = '0;
                    y_d = y_wrap ? '0 : (y_q + DIM_W'(1));
                end
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            blk_q <= blk_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// JPEG MCU scheduler: after SOS, issues one block-decode command at a time to the
// entropy decoder in raster MCU order, waiting for each block to finish.
module jpeg_mcu_scheduler
    import jpeg_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_scan,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [1:0]       samp_mode,
    input  logic [5:0]       cfg_qt,
    input  logic [2:0]       cfg_ht,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_comp,
    output logic [2:0]       cmd_blk,
    output logic [1:0]       cmd_qt,
    output logic             cmd_ht,
    output logic             cmd_dc_clr,
    input  logic             blk_done,
    output logic [DIM_W-1:0] mcu_x,
    output logic [DIM_W-1:0] mcu_y,
    output logic             busy,
    output logic             scan_done
);

    state_e           state_q, state_d;
    samp_mode_e       mode_q, mode_d;
    logic [5:0]       qt_q, qt_d;
    logic [2:0]       ht_q, ht_d;
    logic             empty_q, empty_d;
    logic [DIM_W-1:0] x_last_q, x_last_d;
    logic [DIM_W-1:0] y_last_q, y_last_d;

    samp_mode_e       start_mode;
    logic [DIM_W-1:0] w_m1, h_m1;
    logic             scan_start;
    logic             cnt_adv;
    logic             cnt_last;
    logic [2:0]       blk;
    comp_e            comp;

    // A start is only honoured from IDLE, and abort beats it.
    assign scan_start = (state_q == ST_IDLE) && start_scan && !abort;
    assign cnt_adv    = (state_q == ST_WAIT) && blk_done && !abort;
    assign start_mode = norm_mode(samp_mode);
    // Last MCU index is floor((dim-1)/size), i.e. ceil(dim/size)-1.
    assign w_m1       = img_width - DIM_W'(1);
    assign h_m1       = img_height - DIM_W'(1);

    jpeg_mcu_counter #(
        .DIM_W (DIM_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (scan_start || abort),
        .adv      (cnt_adv),
        .blk_last (last_blk(mode_q)),
        .x_last   (x_last_q),
        .y_last   (y_last_q),
        .blk      (blk),
        .x        (mcu_x),
        .y        (mcu_y),
        .last     (cnt_last)
    );

    // Snapshot of the scan configuration taken when a scan is accepted.
    always_comb begin
        mode_d   = mode_q;
        qt_d     = qt_q;
        ht_d     = ht_q;
        empty_d  = empty_q;
        x_last_d = x_last_q;
        y_last_d = y_last_q;
        if (scan_start) begin
            mode_d   = start_mode;
            qt_d     = cfg_qt;
            ht_d     = cfg_ht;
            empty_d  = (img_width == '0) || (img_height == '0);
            x_last_d = (start_mode == SAMP_420) ? (w_m1 >> 4) : (w_m1 >> 3);
            y_last_d = (start_mode == SAMP_420) ? (h_m1 >> 4) : (h_m1 >> 3);
        end
    end

    // Configuration snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= SAMP_GRAY;
            qt_q     <= '0;
            ht_q     <= '0;
            empty_q  <= 1'b0;
            x_last_q <= '0;
            y_last_q <= '0;
        end else begin
            mode_q   <= mode_d;
            qt_q     <= qt_d;
            ht_q     <= ht_d;
            empty_q  <= empty_d;
            x_last_q <= x_last_d;
            y_last_q <= y_last_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; an empty image passes through ISSUE silently so that
    // scan_done lands two cycles after start_scan.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_scan) state_d = ST_ISSUE;
                ST_ISSUE: begin
                    if (empty_q) begin
                        state_d = ST_DONE;
                    end else if (cmd_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT:  if (blk_done) state_d = cnt_last ? ST_DONE : ST_ISSUE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and command fields derived from the current position.
    always_comb begin
        comp       = blk_comp(mode_q, blk);
        cmd_valid  = (state_q == ST_ISSUE) && !empty_q;
        busy       = (state_q != ST_IDLE);
        scan_done  = (state_q == ST_DONE);
        cmd_comp   = comp;
        cmd_blk    = blk;
        cmd_dc_clr = cmd_valid && (blk == 3'd0) && (mcu_x == '0) && (mcu_y == '0);
        case (comp)
            COMP_CB: begin
                cmd_qt = qt_q[3:2];
                cmd_ht = ht_q[1];
            end
            COMP_CR: begin
                cmd_qt = qt_q[5:4];
                cmd_ht = ht_q[2];
            end
            default: begin
                cmd_qt = qt_q[1:0];
                cmd_ht = ht_q[0];
            end
        endcase
    end

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Testbench for jpeg_mcu_scheduler: table-driven scans, directed abort/reset
// sequences and randomized scans checked against a raster-order command model.
`timescale 1ns/1ps
module tb_jpeg_mcu_scheduler;

    localparam int DIM_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_scan = 1'b0;
    logic             abort = 1'b0;
    logic [DIM_W-1:0] img_width = '0;
    logic [DIM_W-1:0] img_height = '0;
    logic [1:0]       samp_mode = '0;
    logic [5:0]       cfg_qt = '0;
    logic [2:0]       cfg_ht = '0;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [1:0]       cmd_comp;
    logic [2:0]       cmd_blk;
    logic [1:0]       cmd_qt;
    logic             cmd_ht;
    logic             cmd_dc_clr;
    logic             blk_done = 1'b0;
    logic [DIM_W-1:0] mcu_x, mcu_y;
    logic             busy, scan_done;

    int vec_cnt = 0;
    int miss_cnt = 0;

    typedef struct {
        int comp; int blk; int qt; int ht; int dc; int x; int y;
    } cmd_t;

    typedef struct {
        int mode; int w; int h; logic [5:0] qt; logic [2:0] ht;
        int hold; bit spur; int exp_n;
    } vec_t;

    cmd_t exp_q[$];

    jpeg_mcu_scheduler #(.DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_scan (start_scan),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .samp_mode  (samp_mode),
        .cfg_qt     (cfg_qt),
        .cfg_ht     (cfg_ht),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_comp   (cmd_comp),
        .cmd_blk    (cmd_blk),
        .cmd_qt     (cmd_qt),
        .cmd_ht     (cmd_ht),
        .cmd_dc_clr (cmd_dc_clr),
        .blk_done   (blk_done),
        .mcu_x      (mcu_x),
        .mcu_y      (mcu_y),
        .busy       (busy),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_scan = 1'b0;
        abort = 1'b0;
        blk_done = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Expected command stream: every MCU in raster order, every block of the MCU.
    task automatic build_model(input int mode_in, input int w, input int h,
                               input logic [5:0] qt, input logic [2:0] ht);
        int mode, size, nx, ny;
        int comps[$];
        cmd_t c;
        exp_q.delete();
        mode = (mode_in == 3) ? 0 : mode_in;
        if (mode == 1)      comps = '{0, 1, 2};
        else if (mode == 2) comps = '{0, 0, 0, 0, 1, 2};
        else                comps = '{0};
        size = (mode == 2) ? 16 : 8;
        if (w == 0 || h == 0) return;
        nx = (w + size - 1) / size;
        ny = (h + size - 1) / size;
        for (int y = 0; y < ny; y++)
            for (int x = 0; x < nx; x++)
                for (int b = 0; b < comps.size(); b++) begin
                    c.comp = comps[b];
                    c.blk  = b;
                    c.qt   = (int'(qt) >> (2 * comps[b])) & 3;
                    c.ht   = (int'(ht) >> comps[b]) & 1;
                    c.dc   = (x == 0 && y == 0 && b == 0) ? 1 : 0;
                    c.x    = x;
                    c.y    = y;
                    exp_q.push_back(c);
                end
    endtask

    // Drive one whole scan, checking every command against the model queue.
    // hold < 0 picks a random number of not-ready cycles per command.
    task automatic run_scan(input int mode, input int w, input int h,
                            input logic [5:0] qt, input logic [2:0] ht,
                            input int hold, input bit spur, input int abort_at,
                            output int ncmd);
        cmd_t e;
        int   wait_n, gap;
        build_model(mode, w, h, qt, ht);
        ncmd = 0;
        @(negedge clk);
        samp_mode  = mode[1:0];
        img_width  = w[DIM_W-1:0];
        img_height = h[DIM_W-1:0];
        cfg_qt     = qt;
        cfg_ht     = ht;
        start_scan = 1'b1;
        @(negedge clk);
        start_scan = 1'b0;
        img_width  = DIM_W'($urandom);
        img_height = DIM_W'($urandom);
        samp_mode  = 2'($urandom);
        cfg_qt     = 6'($urandom);
        cfg_ht     = 3'($urandom);
        if (exp_q.size() == 0) begin
            chk("empty_valid_c1", cmd_valid, 0);
            chk("empty_busy_c1", busy, 1);
            chk("empty_done_c1", scan_done, 0);
            @(negedge clk);
            chk("empty_done_c2", scan_done, 1);
            chk("empty_valid_c2", cmd_valid, 0);
            @(negedge clk);
            chk("empty_done_c3", scan_done, 0);
            chk("empty_busy_c3", busy, 0);
            return;
        end
        while (exp_q.size() > 0) begin
            e = exp_q[0];
            wait_n = (hold >= 0) ? hold : int'($urandom_range(0, 3));
            for (int i = 0; i <= wait_n; i++) begin
                chk("cmd_valid", cmd_valid, 1);
                if (cmd_valid !== 1'b1) begin
                    do_reset();
                    exp_q.delete();
                    return;
                end
                chk("busy_issue", busy, 1);
                chk("cmd_comp", cmd_comp, e.comp);
                chk("cmd_blk", cmd_blk, e.blk);
                chk("cmd_qt", cmd_qt, e.qt);
                chk("cmd_ht", cmd_ht, e.ht);
                chk("cmd_dc_clr", cmd_dc_clr, e.dc);
                chk("mcu_x", mcu_x, e.x);
                chk("mcu_y", mcu_y, e.y);
                cmd_ready  = (i == wait_n);
                blk_done   = spur && (i != wait_n);
                start_scan = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                cmd_ready  = 1'b0;
                blk_done   = 1'b0;
                start_scan = 1'b0;
            end
            ncmd++;
            void'(exp_q.pop_front());
            chk("wait_valid", cmd_valid, 0);
            if (ncmd == abort_at) begin
                abort      = 1'b1;
                blk_done   = 1'b1;
                start_scan = 1'b1;
                @(negedge clk);
                abort      = 1'b0;
                blk_done   = 1'b0;
                start_scan = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_valid", cmd_valid, 0);
                chk("abort_done", scan_done, 0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("abort_idle_done", scan_done, 0);
                    chk("abort_idle_busy", busy, 0);
                end
                exp_q.delete();
                return;
            end
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) begin
                start_scan = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                start_scan = 1'b0;
                chk("wait_valid", cmd_valid, 0);
                chk("wait_done", scan_done, 0);
            end
            blk_done = 1'b1;
            @(negedge clk);
            blk_done = 1'b0;
            if (exp_q.size() == 0) begin
                chk("scan_done_pulse", scan_done, 1);
                chk("scan_done_busy", busy, 1);
                chk("scan_done_valid", cmd_valid, 0);
                @(negedge clk);
                chk("scan_done_clear", scan_done, 0);
                chk("busy_after_done", busy, 0);
            end
        end
    endtask

    initial begin
        vec_t tbl[9];
        int   ncmd, w, h, md, sz;

        tbl[0] = '{mode:0, w:8,  h:8,  qt:6'b00_00_00, ht:3'b000, hold:0,  spur:0, exp_n:1};
        tbl[1] = '{mode:2, w:16, h:16, qt:6'b01_01_00, ht:3'b110, hold:0,  spur:0, exp_n:6};
        tbl[2] = '{mode:1, w:17, h:9,  qt:6'b10_01_11, ht:3'b101, hold:-1, spur:0, exp_n:18};
        tbl[3] = '{mode:1, w:8,  h:8,  qt:6'b11_10_01, ht:3'b010, hold:5,  spur:1, exp_n:3};
        tbl[4] = '{mode:0, w:0,  h:5,  qt:6'b11_11_11, ht:3'b111, hold:0,  spur:0, exp_n:0};
        tbl[5] = '{mode:3, w:9,  h:8,  qt:6'b00_00_10, ht:3'b001, hold:-1, spur:0, exp_n:2};
        tbl[6] = '{mode:2, w:17, h:1,  qt:6'b11_10_01, ht:3'b011, hold:-1, spur:1, exp_n:12};
        tbl[7] = '{mode:1, w:8,  h:0,  qt:6'b01_01_01, ht:3'b111, hold:0,  spur:0, exp_n:0};
        tbl[8] = '{mode:2, w:1,  h:33, qt:6'b00_11_10, ht:3'b100, hold:-1, spur:0, exp_n:18};

        // Reset state, both held and just released.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_done", scan_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_valid", cmd_valid, 0);
        chk("rel_dc_clr", cmd_dc_clr, 0);
        chk("rel_mcu_x", mcu_x, 0);
        chk("rel_mcu_y", mcu_y, 0);
        chk("rel_cmd", {cmd_comp, cmd_blk, cmd_qt, cmd_ht}, 0);

        for (int i = 0; i < 9; i++) begin
            run_scan(tbl[i].mode, tbl[i].w, tbl[i].h, tbl[i].qt, tbl[i].ht,
                     tbl[i].hold, tbl[i].spur, -1, ncmd);
            chk("tbl_ncmd", ncmd, tbl[i].exp_n);
        end

        // Abort after the third block of a large 4:2:0 scan, then a clean restart.
        run_scan(2, 160, 120, 6'b10_01_00, 3'b010, -1, 0, 3, ncmd);
        chk("abort_ncmd", ncmd, 3);
        run_scan(2, 160, 120, 6'b10_01_00, 3'b010, 0, 0, -1, ncmd);
        chk("restart_ncmd", ncmd, 480);

        // Asynchronous reset in the middle of WAIT, at MCU column 1.
        @(negedge clk);
        samp_mode = 2'd1; img_width = 16'd32; img_height = 16'd8;
        cfg_qt = 6'b11_11_11; cfg_ht = 3'b111; start_scan = 1'b1;
        @(negedge clk);
        start_scan = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("rseq_valid", cmd_valid, 1);
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            if (k < 4) begin
                blk_done = 1'b1;
                @(negedge clk);
                blk_done = 1'b0;
            end
        end
        chk("rseq_mcu_x_pre", mcu_x, 1);
        chk("rseq_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", cmd_valid, 0);
        chk("arst_done", scan_done, 0);
        chk("arst_mcu_x", mcu_x, 0);
        chk("arst_mcu_y", mcu_y, 0);
        chk("arst_cmd", {cmd_comp, cmd_blk, cmd_qt, cmd_ht, cmd_dc_clr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_busy", busy, 0);

        // Randomized scans against the model.
        for (int r = 0; r < 15; r++) begin
            md = $urandom_range(0, 3);
            w  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 48));
            h  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 48));
            run_scan(md, w, h, 6'($urandom), 3'($urandom), -1, 1'($urandom), -1, ncmd);
            sz = (md == 2) ? 16 : 8;
            chk("rand_ncmd", ncmd,
                ((w + sz - 1) / sz) * ((h + sz - 1) / sz) * ((md == 1) ? 3 : ((md == 2) ? 6 : 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
